axis_packet_arbiter: RTL

AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

---
 rtl/axis_packet_arbiter_pkg.sv | 22 ++
 rtl/axis_packet_arbiter_rr_pick.sv | 43 ++++
 rtl/axis_packet_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/axis_packet_arbiter_pkg.sv
// Purpose : shared types and helpers for the packet arbiter and its round-robin picker.
// Latency : n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   arb_state_t  - arbiter FSM encoding (IDLE / LOCKED).
//   rr_distance  - position of a port in round-robin order starting after last_grant.

package axis_packet_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Distance of port idx from the search start (last + 1) mod n.
  // Distance 0 is the highest priority; n-1 is the last grant itself.
  function automatic int rr_distance(input int idx, input int last, input int n);
    return (idx + n - 1 - last) % n;
  endfunction

endpackage

// File: rtl/axis_packet_arbiter_rr_pick.sv
// Purpose : combinational round-robin search over a request vector.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to register the result.
//
// Ports:
//   req        in  NUM_PORTS  request vector, one bit per source.
//   last_grant in  ID_W       index granted most recently; search starts at the next one.
//   grant      out ID_W       winning index (0 when no request).
//   any_req    out 1          at least one request bit is set.

module axis_rr_pick
  import axis_packet_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ID_W      = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ID_W-1:0]      last_grant,
  output logic [ID_W-1:0]      grant,
  output logic                 any_req
);

  int best_dist;
  int cur_dist;

  // Every port is ranked by its distance from last_grant+1; the requesting
  // port with the smallest distance wins. Distances are unique, so no ties.
  always_comb begin
    grant     = '0;
    any_req   = 1'b0;
    best_dist = NUM_PORTS;
    cur_dist  = 0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      cur_dist = rr_distance(j, int'(last_grant), NUM_PORTS);
      if (req[j] && (cur_dist < best_dist)) begin
        best_dist = cur_dist;
        grant     = ID_W'(j);
        any_req   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Purpose : merges NUM_PORTS AXI-stream byte sources into one stream, whole packets at a time.
// Latency : 1 cycle input-to-output; one idle arbitration cycle between packets.
// Backpressure: o_tready to the granted source only, when the output register is empty or draining.
//
// Ports:
//   i_clk     in  1            clock.
//   i_rst     in  1            synchronous active-high reset.
//   i_tdata   in  8*NUM_PORTS  source bytes, port n at [8n+7:8n].
//   i_tlast   in  NUM_PORTS    last byte of a packet, per source.
//   i_tvalid  in  NUM_PORTS    byte valid, per source.
//   o_tready  out NUM_PORTS    byte accepted, per source.
//   o_tdata   out 8            merged stream byte.
//   o_tlast   out 1            merged packet end.
//   o_tvalid  out 1            merged byte valid.
//   i_tready  in  1            downstream accept.
//   o_tid     out ID_W         source index of the byte on o_tdata.

module axis_packet_arbiter
  import axis_packet_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ID_W      = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [8*NUM_PORTS-1:0] i_tdata,
  input  logic [NUM_PORTS-1:0]   i_tlast,
  input  logic [NUM_PORTS-1:0]   i_tvalid,
  output logic [NUM_PORTS-1:0]   o_tready,
  output logic [7:0]             o_tdata,
  output logic                   o_tlast,
  output logic                   o_tvalid,
  input  logic                   i_tready,
  output logic [ID_W-1:0]        o_tid
);

  arb_state_t      state;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] pick;
  logic            any_req;

  logic [7:0]      sel_data;
  logic            sel_last;
  logic            sel_valid;
  logic            accept;

  axis_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .ID_W      (ID_W)
  ) u_rr_pick (
    .req        (i_tvalid),
    .last_grant (last_grant),
    .grant      (pick),
    .any_req    (any_req)
  );

  // Mux the granted source onto the internal beat bus.
  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (grant == ID_W'(j)) begin
        sel_data  = i_tdata[8*j +: 8];
        sel_last  = i_tlast[j];
        sel_valid = i_tvalid[j];
      end
    end
  end

  // A beat is taken only from the locked source, and only when the single
  // output register is empty or being drained this cycle. Reset blocks any
  // acceptance so a byte seen during reset is never silently consumed.
  assign accept = (state == LOCKED) & ~i_rst & sel_valid & (~o_tvalid | i_tready);

  always_comb begin
    o_tready = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (grant == ID_W'(j)) begin
        o_tready[j] = accept;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      grant      <= '0;
      // Start the search just past the top port so port 0 wins first.
      last_grant <= ID_W'(NUM_PORTS - 1);
      o_tvalid   <= 1'b0;
      o_tdata    <= '0;
      o_tlast    <= 1'b0;
      o_tid      <= '0;
    end else begin
      // Output register: load on accept, otherwise drop valid once drained.
      // With no accept and no i_tready the held beat stays untouched.
      if (accept) begin
        o_tvalid <= 1'b1;
        o_tdata  <= sel_data;
        o_tlast  <= sel_last;
        o_tid    <= grant;
      end else if (i_tready) begin
        o_tvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (any_req) begin
            grant <= pick;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          // Stay on this source until its tlast beat is taken, even if it
          // stalls; other sources wait for the next arbitration.
          if (accept && sel_last) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
